// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame parser: FSM state encoding,
// frame geometry and the default header/tail bytes.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H1   = 3'd1,
        ST_PAY  = 3'd2,
        ST_CHK  = 3'd3,
        ST_TL   = 3'd4
    } state_e;

    localparam int FRAME_LEN = 9;
    localparam int PAY_LEN   = 5;

    localparam logic [7:0]  DEF_HEAD0    = 8'h55;
    localparam logic [7:0]  DEF_HEAD1    = 8'hA5;
    localparam logic [7:0]  DEF_TAIL     = 8'hF0;
    localparam logic [31:0] DEF_TIME_RST = 32'd24_999_999;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer. Counts clocks while enabled; a clear always wins.
// expire_o is a combinational one-cycle pulse in the cycle the count sits at
// TIMEOUT_CYC-1 with no clear, so a byte arriving in that cycle suppresses it.
module uart_gap_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and expiry detection; clear has priority over counting.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q == LAST) begin
                expire_o = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_frame_parser.sv
// Assembles 9-byte command frames (H0 H1 T3 T2 T1 T0 CTRL CHK TAIL) from the
// UART byte strobe, checks header/XOR/tail and atomically loads Ctrl and
// Time_set. A checksum mismatch is only reported at the tail byte so the
// frame length is fixed. Dbg_State exposes the FSM state for observation.
module uart_cmd_frame_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  HEAD0       = DEF_HEAD0,
    parameter logic [7:0]  HEAD1       = DEF_HEAD1,
    parameter logic [7:0]  TAIL        = DEF_TAIL,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter logic [31:0] TIME_RST    = DEF_TIME_RST
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  Rx_Data,
    input  logic        Rx_Done,
    output logic [7:0]  Ctrl,
    output logic [31:0] Time_set,
    output logic        Frame_Done,
    output logic        Frame_Err,
    output logic [2:0]  Dbg_State
);

    localparam logic [2:0] LAST_IDX = 3'(PAY_LEN - 1);

    state_e      state_q, state_d;
    logic [39:0] payload_q, payload_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  xor_q, xor_d;
    logic        match_q, match_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [31:0] time_q, time_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        expire;

    // Gap timer runs only while a frame is in progress.
    uart_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .clear_i  (Rx_Done || (state_q == ST_IDLE)),
        .enable_i (state_q != ST_IDLE),
        .expire_o (expire)
    );

    // Frame FSM: advances only on byte strobes; a byte beats a timeout.
    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        match_d   = match_q;
        ctrl_d    = ctrl_q;
        time_d    = time_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (Rx_Done) begin
            case (state_q)
                ST_IDLE: begin
                    if (Rx_Data == HEAD0) state_d = ST_H1;
                end
                ST_H1: begin
                    if (Rx_Data == HEAD1) begin
                        state_d = ST_PAY;
                        idx_d   = '0;
                        xor_d   = '0;
                    end else if (Rx_Data != HEAD0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PAY: begin
                    payload_d = {payload_q[31:0], Rx_Data};
                    xor_d     = xor_q ^ Rx_Data;
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) state_d = ST_CHK;
                end
                ST_CHK: begin
                    match_d = (Rx_Data == xor_q);
                    state_d = ST_TL;
                end
                ST_TL: begin
                    if ((Rx_Data == TAIL) && match_q) begin
                        time_d = payload_q[39:8];
                        ctrl_d = payload_q[7:0];
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (expire) begin
            state_d   = ST_IDLE;
            payload_d = '0;
            err_d     = 1'b1;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            payload_q <= '0;
            idx_q     <= '0;
            xor_q     <= '0;
            match_q   <= 1'b0;
            ctrl_q    <= '0;
            time_q    <= TIME_RST;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            match_q   <= match_d;
            ctrl_q    <= ctrl_d;
            time_q    <= time_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign Ctrl       = ctrl_q;
    assign Time_set   = time_q;
    assign Frame_Done = done_q;
    assign Frame_Err  = err_q;
    assign Dbg_State  = state_q;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Bench for uart_cmd_frame_parser: table of whole frames, hand-written
// corner sequences (resync, timeout, byte-in-expiry-cycle, mid-frame reset)
// and a randomized stream, all checked every cycle against a frame-level
// model that keeps the bytes of the current partial frame in a queue.
module tb_uart_cmd_frame_parser;
    import uart_cmd_pkg::*;

    localparam int          TO   = 40;
    localparam logic [31:0] TRST = 32'd24_999_999;
    localparam logic [7:0]  H0   = 8'h55;
    localparam logic [7:0]  H1   = 8'hA5;
    localparam logic [7:0]  TL   = 8'hF0;

    logic        Clk, Reset_n, Rx_Done;
    logic [7:0]  Rx_Data, Ctrl;
    logic [31:0] Time_set;
    logic        Frame_Done, Frame_Err;
    logic [2:0]  Dbg_State;

    int n_pass = 0;
    int n_total = 0;

    uart_cmd_frame_parser #(
        .HEAD0       (H0),
        .HEAD1       (H1),
        .TAIL        (TL),
        .TIMEOUT_CYC (TO),
        .TIME_RST    (TRST)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Rx_Data    (Rx_Data),
        .Rx_Done    (Rx_Done),
        .Ctrl       (Ctrl),
        .Time_set   (Time_set),
        .Frame_Done (Frame_Done),
        .Frame_Err  (Frame_Err),
        .Dbg_State  (Dbg_State)
    );

    // Clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    logic [7:0]  win[$];
    int          gap;
    logic [7:0]  m_ctrl;
    logic [31:0] m_time;
    logic        m_done, m_err;

    task automatic model_reset();
        win.delete();
        gap    = 0;
        m_ctrl = 8'h00;
        m_time = TRST;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] x;
        m_done = 1'b0;
        m_err  = 1'b0;
        gap    = 0;
        if (win.size() == 0) begin
            if (b == H0) win.push_back(b);
        end else if (win.size() == 1) begin
            if (b == H1) win.push_back(b);
            else if (b != H0) win.delete();
        end else begin
            win.push_back(b);
            if (win.size() == FRAME_LEN) begin
                x = 8'h00;
                for (int i = 2; i < 7; i++) x ^= win[i];
                if (win[7] == x && win[8] == TL) begin
                    m_time = {win[2], win[3], win[4], win[5]};
                    m_ctrl = win[6];
                    m_done = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                win.delete();
            end
        end
    endtask

    task automatic model_idle();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (win.size() != 0) begin
            gap++;
            if (gap == TO) begin
                m_err = 1'b1;
                win.delete();
                gap = 0;
            end
        end else begin
            gap = 0;
        end
    endtask

    function automatic logic [2:0] exp_state();
        int n;
        n = win.size();
        if (n == 0) return ST_IDLE;
        if (n == 1) return ST_H1;
        if (n <= 6) return ST_PAY;
        if (n == 7) return ST_CHK;
        return ST_TL;
    endfunction

    function automatic logic [71:0] make_frame(input logic [31:0] t, input logic [7:0] c);
        logic [7:0] chk;
        chk = t[31:24] ^ t[23:16] ^ t[15:8] ^ t[7:0] ^ c;
        return {H0, H1, t, c, chk, TL};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_cycle(input string tag);
        check({tag, ".done"},  {31'd0, Frame_Done}, {31'd0, m_done});
        check({tag, ".err"},   {31'd0, Frame_Err},  {31'd0, m_err});
        check({tag, ".ctrl"},  {24'd0, Ctrl},       {24'd0, m_ctrl});
        check({tag, ".time"},  Time_set,            m_time);
        check({tag, ".state"}, {29'd0, Dbg_State},  {29'd0, exp_state()});
    endtask

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic send_byte(input logic [7:0] b);
        Rx_Data = b;
        Rx_Done = 1'b1;
        model_byte(b);
        @(posedge Clk);
        #1;
        Rx_Done = 1'b0;
        Rx_Data = $urandom_range(0, 255);
        check_cycle("byte");
    endtask

    task automatic idle_cycle();
        model_idle();
        @(posedge Clk);
        #1;
        check_cycle("idle");
    endtask

    task automatic send_frame(input logic [71:0] f);
        for (int i = 0; i < FRAME_LEN; i++) send_byte(f[71-8*i -: 8]);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [71:0] frame;
        logic        acc;
        logic [7:0]  ctrl;
        logic [31:0] tim;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [71:0] f;
        logic [31:0] t;
        logic [7:0]  c;
        int          kind, k;

        // The XOR of payload 00 2F AF 07 0F is 8'h88.
        tbl[0] = '{72'h55A5002FAF070F88F0, 1'b1, 8'h0F, 32'h002FAF07};
        tbl[1] = '{72'h55A5002FAF070F8BF0, 1'b0, 8'h0F, 32'h002FAF07};
        tbl[2] = '{72'h55A5002FAF070F8AF0, 1'b0, 8'h0F, 32'h002FAF07};
        tbl[3] = '{72'h55A500000100AAABF0, 1'b1, 8'hAA, 32'h00000100};
        tbl[4] = '{72'h55A500000100AAABF1, 1'b0, 8'hAA, 32'h00000100};
        tbl[5] = '{72'h55A5FFFFFFFF0000F0, 1'b1, 8'h00, 32'hFFFFFFFF};

        // Reset.
        Reset_n = 1'b0;
        Rx_Done = 1'b0;
        Rx_Data = 8'h00;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check("rst.ctrl",  {24'd0, Ctrl}, 32'h0);
        check("rst.time",  Time_set, TRST);
        check("rst.done",  {31'd0, Frame_Done}, 32'd0);
        check("rst.err",   {31'd0, Frame_Err}, 32'd0);
        check("rst.state", {29'd0, Dbg_State}, {29'd0, ST_IDLE});
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Table frames, back to back.
        for (int v = 0; v < 6; v++) begin
            send_frame(tbl[v].frame);
            check("tbl.done", {31'd0, Frame_Done}, {31'd0, tbl[v].acc});
            check("tbl.err",  {31'd0, Frame_Err},  {31'd0, ~tbl[v].acc});
            check("tbl.ctrl", {24'd0, Ctrl}, {24'd0, tbl[v].ctrl});
            check("tbl.time", Time_set, tbl[v].tim);
        end
        repeat (3) idle_cycle();

        // Lone noise byte then H1 resync (55 55 A5 ...).
        send_byte(8'h12);
        check("noise.err", {31'd0, Frame_Err}, 32'd0);
        send_byte(H0);
        f = make_frame(32'h12345678, 8'h3C);
        send_frame(f);
        check("resync.done", {31'd0, Frame_Done}, 32'd1);
        check("resync.time", Time_set, 32'h12345678);
        check("resync.ctrl", {24'd0, Ctrl}, 32'h3C);
        idle_cycle();

        // Header + 3 payload bytes, then a gap long enough to time out.
        send_byte(H0); send_byte(H1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        for (int i = 1; i < TO; i++) idle_cycle();
        check("to.pre_err", {31'd0, Frame_Err}, 32'd0);
        idle_cycle();
        check("to.err",   {31'd0, Frame_Err}, 32'd1);
        check("to.state", {29'd0, Dbg_State}, {29'd0, ST_IDLE});
        idle_cycle();
        check("to.err_len", {31'd0, Frame_Err}, 32'd0);
        send_frame(make_frame(32'hCAFE0001, 8'h81));
        check("to.next_done", {31'd0, Frame_Done}, 32'd1);

        // Byte arriving exactly in the expiry cycle is consumed.
        send_byte(H0); send_byte(H1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        for (int i = 1; i < TO; i++) idle_cycle();
        send_byte(8'h44);
        check("exp.no_err", {31'd0, Frame_Err}, 32'd0);
        send_byte(8'h55); send_byte(8'h11); send_byte(TL);
        check("exp.done", {31'd0, Frame_Done}, 32'd1);
        check("exp.time", Time_set, 32'h11223344);
        check("exp.ctrl", {24'd0, Ctrl}, 32'h55);

        // Reset in the middle of the payload.
        send_byte(H0); send_byte(H1); send_byte(8'h01); send_byte(8'h02);
        Reset_n = 1'b0;
        #1;
        check("mrst.ctrl",  {24'd0, Ctrl}, 32'h0);
        check("mrst.time",  Time_set, TRST);
        check("mrst.state", {29'd0, Dbg_State}, {29'd0, ST_IDLE});
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        send_frame(make_frame(32'h00BEEF00, 8'h5A));
        check("mrst.done", {31'd0, Frame_Done}, 32'd1);
        check("mrst.time", Time_set, 32'h00BEEF00);

        // Randomized stream.
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 4);
            t = $urandom();
            c = $urandom_range(0, 255);
            f = make_frame(t, c);
            if (kind == 1) begin
                k = $urandom_range(0, FRAME_LEN - 1);
                f[71-8*k -: 8] = f[71-8*k -: 8] ^ 8'($urandom_range(1, 255));
            end
            if (kind <= 1) begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    send_byte(f[71-8*i -: 8]);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) idle_cycle();
                end
            end else if (kind == 2) begin
                repeat ($urandom_range(1, 3)) send_byte(($urandom_range(0, 1) == 1) ? H0 : 8'($urandom_range(0, 255)));
            end else if (kind == 3) begin
                k = $urandom_range(1, FRAME_LEN - 1);
                for (int i = 0; i < k; i++) send_byte(f[71-8*i -: 8]);
                repeat (TO + $urandom_range(0, 4)) idle_cycle();
            end else begin
                repeat ($urandom_range(0, 4)) idle_cycle();
            end
        end
        repeat (TO + 2) idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
